// File: rtl/inst_fetch_buf.sv
// Fetch stage between the PC register and decode: one outstanding imem read, responses queued with their PC.
// Build option IF_BYPASS_EN lets a response reach decode in the cycle it returns when the queue is empty.
module inst_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          inst_ce,
  output logic          pc_stall,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_rvalid,
  output logic          if_valid,
  output logic [31:0]   if_inst,
  output logic [AW-1:0] if_pc,
  input  logic          id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];
  logic [AW-1:0] pend_pc_q, pend_pc_d;
  logic          imem_req_q, imem_req_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;

  logic          fifo_nonempty_s;
  logic          rsp_s;
  logic          byp_s;
  logic          pop_s;
  logic          fifo_pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW-1:0] occ_s;
  logic [CW-1:0] occ_after_s;

  assign fifo_nonempty_s = (count_q != {CW{1'b0}});
  assign rsp_s           = (state_q == S_BUSY) && imem_rvalid;

`ifdef IF_BYPASS_EN
  assign byp_s   = !fifo_nonempty_s && rsp_s && !flush;
  assign if_inst = byp_s ? imem_rdata : inst_mem_q[rd_ptr_q];
  assign if_pc   = byp_s ? pend_pc_q  : pc_mem_q[rd_ptr_q];
`else
  assign byp_s   = 1'b0;
  assign if_inst = inst_mem_q[rd_ptr_q];
  assign if_pc   = pc_mem_q[rd_ptr_q];
`endif

  assign if_valid   = fifo_nonempty_s || byp_s;
  assign pop_s      = if_valid && id_ready;
  assign fifo_pop_s = pop_s && fifo_nonempty_s && !flush;
  // A bypassed response consumed by decode never occupies a slot.
  assign push_s     = rsp_s && !flush && !(byp_s && id_ready);

  // The outstanding request holds a credit, so a new issue needs room for both responses.
  assign occ_s       = count_q + CW'(state_q != S_IDLE);
  assign occ_after_s = occ_s - CW'(pop_s);
  assign issue_s     = inst_ce && !flush && (state_q != S_DROP) &&
                       ((state_q == S_IDLE) || imem_rvalid) && (occ_after_s < DEPTH_C);

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  // Back-pressure toward the PC register.
  always_comb begin
    if (rst) begin
      pc_stall = 1'b1;
    end else if (flush || (state_q == S_DROP)) begin
      pc_stall = 1'b1;
    end else if (inst_ce) begin
      pc_stall = !issue_s;
    end else begin
      pc_stall = 1'b0;
    end
  end

  // Request tracking state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue_s) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = imem_rvalid ? S_IDLE : S_DROP;
        end else if (imem_rvalid) begin
          state_d = issue_s ? S_BUSY : S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue pointer and occupancy update.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = {CW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (fifo_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(fifo_pop_s);
    end
  end

  // Request issue and pending PC capture.
  always_comb begin
    imem_req_d  = issue_s;
    imem_addr_d = imem_addr_q;
    pend_pc_d   = pend_pc_q;
    if (issue_s) begin
      imem_addr_d = pc;
      pend_pc_d   = pc;
    end else begin
      imem_addr_d = imem_addr_q;
      pend_pc_d   = pend_pc_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= {CW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      pend_pc_q   <= {AW{1'b0}};
      imem_req_q  <= 1'b0;
      imem_addr_q <= {AW{1'b0}};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_pc_q   <= pend_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= 32'h0000_0000;
        pc_mem_q[i]   <= {AW{1'b0}};
      end
    end else if (push_s) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a simple latency-programmable instruction memory model.
module tb_inst_fetch_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        inst_ce;
  logic        pc_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;

  int n_cmp = 0;
  int n_err = 0;

  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] mem_addr = 32'h0;

`ifdef IF_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif
  localparam logic [31:0] NBYP = 32'd1 - BYP;

  inst_fetch_buf #(.DEPTH(4), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .inst_ce     (inst_ce),
    .pc_stall    (pc_stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the memory answers mem_lat cycles after it sees imem_req.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_rvalid = 1'b0;
      if (mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'h2000_0000 | mem_addr;
        end
      end
      if (imem_req) begin
        mem_cnt  = mem_lat;
        mem_addr = imem_addr;
      end
    end
  endtask

  initial begin
    logic [31:0] next_pc;
    logic [31:0] exp_pc;
    int          delivered;
    int          first_i;
    int          acc;

    rst = 1'b1; pc = 32'h0; inst_ce = 1'b0; flush = 1'b0;
    imem_rdata = 32'h0; imem_rvalid = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid",  32'(if_valid), 32'd0);
    chk("rst_imem_req",  32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_inst",   if_inst, 32'h0);
    chk("rst_if_pc",     if_pc, 32'h0);
    chk("rst_pc_stall",  32'(pc_stall), 32'd1);

    // Streaming, 1-cycle memory, decode always ready.
    tick(); rst = 1'b0; inst_ce = 1'b1; pc = 32'h0; id_ready = 1'b1; #1;
    chk("s_c0_stall", 32'(pc_stall), 32'd0);
    chk("s_c0_req",   32'(imem_req), 32'd0);
    next_pc = 32'h4;
    tick(); pc = next_pc; #1;
    chk("s_c1_req",   32'(imem_req), 32'd1);
    chk("s_c1_addr",  imem_addr, 32'h0);
    chk("s_c1_stall", 32'(pc_stall), 32'd1);
    exp_pc = 32'h0; delivered = 0; first_i = -1;
    for (int i = 0; i < 20; i++) begin
      tick(); inst_ce = (i < 15); pc = next_pc; #1;
      if (inst_ce && !pc_stall) next_pc = next_pc + 32'h4;
      if (if_valid) begin
        if (first_i < 0) first_i = i;
        chk("s_if_pc",   if_pc, exp_pc);
        chk("s_if_inst", if_inst, 32'h2000_0000 | exp_pc);
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end
    end
    chk("s_first_cycle", 32'(first_i), NBYP);
    chk("s_delivered",   32'(delivered), 32'd9);
    chk("s_end_valid",   32'(if_valid), 32'd0);
    chk("s_end_stall",   32'(pc_stall), 32'd0);

    // Fill: decode stalled, exactly four fetches accepted.
    next_pc = 32'h100; acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); inst_ce = 1'b1; pc = next_pc; id_ready = 1'b0; #1;
      if (!pc_stall) begin
        next_pc = next_pc + 32'h4;
        acc++;
      end
    end
    chk("full_accepted", 32'(acc), 32'd4);
    chk("full_stall",    32'(pc_stall), 32'd1);
    chk("full_req",      32'(imem_req), 32'd0);
    chk("full_valid",    32'(if_valid), 32'd1);
    chk("full_head_pc",  if_pc, 32'h100);
    chk("full_head_inst", if_inst, 32'h2000_0100);
    tick(); id_ready = 1'b1; pc = next_pc; #1;
    chk("pulse_stall",  32'(pc_stall), 32'd0);
    chk("pulse_pop_pc", if_pc, 32'h100);
    tick(); id_ready = 1'b0; pc = 32'h114; #1;
    chk("pulse_req",   32'(imem_req), 32'd1);
    chk("pulse_addr",  imem_addr, 32'h110);
    chk("pulse_stall2", 32'(pc_stall), 32'd1);
    chk("pulse_head",  if_pc, 32'h104);

    // Flush coincident with response and pop while fully committed.
    tick(); flush = 1'b1; id_ready = 1'b1; #1;
    chk("fl_rvalid_seen", 32'(imem_rvalid), 32'd1);
    chk("fl_stall",  32'(pc_stall), 32'd1);
    chk("fl_valid",  32'(if_valid), 32'd1);
    tick(); flush = 1'b0; id_ready = 1'b0; inst_ce = 1'b1; pc = 32'h200; #1;
    chk("fl_after_valid", 32'(if_valid), 32'd0);
    chk("fl_after_req",   32'(imem_req), 32'd0);
    chk("fl_after_stall", 32'(pc_stall), 32'd0);
    tick(); inst_ce = 1'b0; #1;
    chk("fl_req2",   32'(imem_req), 32'd1);
    chk("fl_addr2",  imem_addr, 32'h200);
    chk("fl_valid2", 32'(if_valid), 32'd0);
    tick(); #1;
    chk("fl_rsp_valid", 32'(if_valid), BYP);
    tick(); #1;
    chk("fl_q_valid", 32'(if_valid), 32'd1);
    chk("fl_q_pc",    if_pc, 32'h200);
    chk("fl_q_inst",  if_inst, 32'h2000_0200);
    id_ready = 1'b1;
    tick(); id_ready = 1'b0; #1;
    chk("fl_q_empty", 32'(if_valid), 32'd0);

    // Flush while BUSY with 3-cycle memory: response dropped.
    mem_lat = 3;
    tick(); inst_ce = 1'b1; pc = 32'h300; #1;
    chk("dr_c0_stall", 32'(pc_stall), 32'd0);
    tick(); inst_ce = 1'b0; #1;
    chk("dr_c1_req",  32'(imem_req), 32'd1);
    chk("dr_c1_addr", imem_addr, 32'h300);
    tick(); flush = 1'b1; #1;
    chk("dr_c2_stall", 32'(pc_stall), 32'd1);
    tick(); flush = 1'b0; inst_ce = 1'b1; pc = 32'h400; #1;
    chk("dr_c3_stall", 32'(pc_stall), 32'd1);
    chk("dr_c3_valid", 32'(if_valid), 32'd0);
    tick(); #1;
    chk("dr_c4_rvalid", 32'(imem_rvalid), 32'd1);
    chk("dr_c4_stall",  32'(pc_stall), 32'd1);
    chk("dr_c4_valid",  32'(if_valid), 32'd0);
    tick(); #1;
    chk("dr_c5_stall", 32'(pc_stall), 32'd0);
    chk("dr_c5_valid", 32'(if_valid), 32'd0);
    tick(); inst_ce = 1'b0; #1;
    chk("dr_c6_req",  32'(imem_req), 32'd1);
    chk("dr_c6_addr", imem_addr, 32'h400);
    tick(); tick();
    tick(); #1;
    chk("dr_c9_valid", 32'(if_valid), BYP);
    tick(); #1;
    chk("dr_c10_valid", 32'(if_valid), 32'd1);
    chk("dr_c10_pc",    if_pc, 32'h400);
    chk("dr_c10_inst",  if_inst, 32'h2000_0400);
    id_ready = 1'b1;
    tick(); id_ready = 1'b0; #1;
    chk("dr_empty", 32'(if_valid), 32'd0);

    // Response into an empty queue with decode ready (bypass behaviour).
    mem_auto = 1'b0;
    tick(); inst_ce = 1'b1; pc = 32'h500; id_ready = 1'b1; #1;
    chk("bp_c0_stall", 32'(pc_stall), 32'd0);
    tick(); inst_ce = 1'b0; #1;
    chk("bp_c1_req",  32'(imem_req), 32'd1);
    chk("bp_c1_addr", imem_addr, 32'h500);
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; #1;
    chk("bp_c2_valid", 32'(if_valid), BYP);
`ifdef IF_BYPASS_EN
    chk("bp_c2_inst", if_inst, 32'h1234_5678);
    chk("bp_c2_pc",   if_pc, 32'h500);
`endif
    tick(); imem_rvalid = 1'b0; #1;
    chk("bp_c3_valid", 32'(if_valid), NBYP);
`ifndef IF_BYPASS_EN
    chk("bp_c3_inst", if_inst, 32'h1234_5678);
    chk("bp_c3_pc",   if_pc, 32'h500);
`endif
    tick(); #1;
    chk("bp_c4_valid", 32'(if_valid), 32'd0);
    mem_auto = 1'b1;

    // Asynchronous reset while BUSY with two buffered entries.
    mem_lat = 3; id_ready = 1'b0; acc = 0; next_pc = 32'h600;
    for (int i = 0; i < 20 && acc < 3; i++) begin
      tick(); inst_ce = 1'b1; pc = next_pc; #1;
      if (!pc_stall) begin
        acc++;
        next_pc = next_pc + 32'h4;
      end
    end
    chk("mr_accepted", 32'(acc), 32'd3);
    tick(); inst_ce = 1'b0; #1;
    chk("mr_pre_valid", 32'(if_valid), 32'd1);
    chk("mr_pre_req",   32'(imem_req), 32'd1);
    rst = 1'b1; #1;
    mem_cnt = 0; imem_rvalid = 1'b0;
    chk("mr_valid", 32'(if_valid), 32'd0);
    chk("mr_req",   32'(imem_req), 32'd0);
    chk("mr_stall", 32'(pc_stall), 32'd1);
    chk("mr_pc",    if_pc, 32'h0);
    tick(); rst = 1'b0; inst_ce = 1'b1; pc = 32'h0; #1;
    chk("mr_rel_stall", 32'(pc_stall), 32'd0);
    chk("mr_rel_valid", 32'(if_valid), 32'd0);
    tick(); inst_ce = 1'b0; #1;
    chk("mr_rel_req",  32'(imem_req), 32'd1);
    chk("mr_rel_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
